// File: rtl/full_adder_pkg.sv
// Shared constants for the ALU adder hierarchy.
package full_adder_pkg;

  // Widest operand any adder in the hierarchy is built for.
  localparam int ADDER_MAX_WIDTH = 64;

  // Value loaded into single-bit flag registers on reset.
  localparam logic FLAG_RST_VAL = 1'b0;

endpackage : full_adder_pkg

// File: rtl/full_adder_fa_cell.sv
// One-bit full adder cell; the ripple chain in full_adder is built from these.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  // Sum is the parity of the three inputs; carry is their majority.
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule : fa_cell

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a combinational result and a registered
// copy carrying carry-out and two's-complement overflow flags.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             c_out_q,
  output logic             ovf_q
);

  import full_adder_pkg::*;

  if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, ADDER_MAX_WIDTH);
  end

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             ovf;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (c[i]),
      .sum   (s[i]),
      .c_out (c[i+1])
    );
  end

  assign sum   = s;
  assign c_out = c[WIDTH];
  // Carries into and out of the sign bit disagree exactly on signed overflow.
  // For WIDTH=1 the carry into the sign bit is c_in itself.
  assign ovf   = c[WIDTH] ^ c[WIDTH-1];

  // Capture the result when enabled; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= FLAG_RST_VAL;
      ovf_q   <= FLAG_RST_VAL;
    end else if (en) begin
      sum_q   <= sum;
      c_out_q <= c_out;
      ovf_q   <= ovf;
    end
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=64.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;

  // WIDTH=1 instance signals
  logic a1, b1, cin1, en1;
  logic sum1, cout1, sum1_q, cout1_q, ovf1_q;

  // WIDTH=64 instance signals
  logic [63:0] a64, b64;
  logic        cin64, en64;
  logic [63:0] sum64, sum64_q;
  logic        cout64, cout64_q, ovf64_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(cin1), .en(en1),
    .sum(sum1), .c_out(cout1), .sum_q(sum1_q), .c_out_q(cout1_q), .ovf_q(ovf1_q)
  );

  full_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .a(a64), .b(b64), .c_in(cin64), .en(en64),
    .sum(sum64), .c_out(cout64), .sum_q(sum64_q), .c_out_q(cout64_q), .ovf_q(ovf64_q)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic ci);
    return {1'b0, a} + {1'b0, b} + {64'd0, ci};
  endfunction

  // Signed overflow: true signed result falls outside the 64-bit range.
  function automatic logic ref_ovf(input logic [63:0] a, input logic [63:0] b,
                                   input logic ci);
    logic signed [65:0] s;
    s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, ci});
    return (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
  endfunction

  typedef struct {
    logic a, b, ci;
    logic e_sum, e_cout, e_ovf;
  } vec1_t;

  typedef struct {
    string       name;
    logic [63:0] a, b;
    logic        ci;
    logic [63:0] e_sum;
    logic        e_cout, e_ovf;
  } vec64_t;

  vec1_t  v1  [8];
  vec64_t v64 [6];

  initial begin
    logic [64:0] r;
    logic [63:0] m_sum_q;
    logic        m_cout_q, m_ovf_q;
    logic        ov;

    // {a,b,c_in} -> {c_out,sum}; ovf = c_out ^ c_in at WIDTH=1
    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    v1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    v1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    v1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    v64[0] = '{"ones_plus_zero_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
               64'd0, 1'b1, 1'b0};
    v64[1] = '{"pos_overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1};
    v64[2] = '{"ones_plus_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    v64[3] = '{"all_zero", 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0};
    v64[4] = '{"neg_overflow", 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000,
               1'b0, 64'd1, 1'b1, 1'b1};
    v64[5] = '{"three_plus_four", 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    a1 = 0; b1 = 0; cin1 = 0; en1 = 0;
    a64 = 64'h1234; b64 = 64'h5678; cin64 = 1'b1; en64 = 1'b1;
    #1;
    chk("rst_sum64_q", sum64_q, 64'd0);
    chk("rst_cout64_q", {63'd0, cout64_q}, 64'd0);
    chk("rst_ovf64_q", {63'd0, ovf64_q}, 64'd0);
    chk("rst_sum1_q", {63'd0, sum1_q}, 64'd0);
    chk("rst_comb_sum64", sum64, 64'h68AD);
    @(posedge clk); #1;
    chk("rst_hold_sum64_q", sum64_q, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    en64 = 1'b0;

    // WIDTH=1 exhaustive sweep, 10 ns per vector
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = v1[i].a; b1 = v1[i].b; cin1 = v1[i].ci; en1 = 1'b1;
      #1;
      chk($sformatf("w1_sum[%0d]", i), {63'd0, sum1}, {63'd0, v1[i].e_sum});
      chk($sformatf("w1_cout[%0d]", i), {63'd0, cout1}, {63'd0, v1[i].e_cout});
      @(posedge clk); #1;
      chk($sformatf("w1_sum_q[%0d]", i), {63'd0, sum1_q}, {63'd0, v1[i].e_sum});
      chk($sformatf("w1_cout_q[%0d]", i), {63'd0, cout1_q}, {63'd0, v1[i].e_cout});
      chk($sformatf("w1_ovf_q[%0d]", i), {63'd0, ovf1_q}, {63'd0, v1[i].e_ovf});
    end
    @(negedge clk);
    en1 = 1'b0;

    // WIDTH=64 boundary vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a64 = v64[i].a; b64 = v64[i].b; cin64 = v64[i].ci; en64 = 1'b1;
      #1;
      chk({v64[i].name, "_sum"}, sum64, v64[i].e_sum);
      chk({v64[i].name, "_cout"}, {63'd0, cout64}, {63'd0, v64[i].e_cout});
      @(posedge clk); #1;
      chk({v64[i].name, "_sum_q"}, sum64_q, v64[i].e_sum);
      chk({v64[i].name, "_cout_q"}, {63'd0, cout64_q}, {63'd0, v64[i].e_cout});
      chk({v64[i].name, "_ovf_q"}, {63'd0, ovf64_q}, {63'd0, v64[i].e_ovf});
    end

    // Enable hold: sum_q=7 captured above; drive 9+9+1 with en=0
    @(negedge clk);
    a64 = 64'd9; b64 = 64'd9; cin64 = 1'b1; en64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_sum", sum64, 64'd19);
      chk("hold_sum_q", sum64_q, 64'd7);
    end

    // Load all registered outputs nonzero, then reset mid-cycle
    @(negedge clk);
    a64 = 64'h8000_0000_0000_0001; b64 = 64'h8000_0000_0000_0000; cin64 = 1'b0; en64 = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_sum_q", sum64_q, 64'd1);
    chk("pre_rst_cout_q", {63'd0, cout64_q}, 64'd1);
    chk("pre_rst_ovf_q", {63'd0, ovf64_q}, 64'd1);
    @(negedge clk);
    en64 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sum_q", sum64_q, 64'd0);
    chk("async_rst_cout_q", {63'd0, cout64_q}, 64'd0);
    chk("async_rst_ovf_q", {63'd0, ovf64_q}, 64'd0);
    chk("async_rst_comb_sum", sum64, 64'd1);
    #1 rst = 1'b0;

    // Reset and enable together at an edge: reset wins
    @(negedge clk);
    rst = 1'b1; en64 = 1'b1;
    a64 = 64'd5; b64 = 64'd6; cin64 = 1'b0;
    @(posedge clk); #1;
    chk("rst_en_sum_q", sum64_q, 64'd0);
    chk("rst_en_cout_q", {63'd0, cout64_q}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_capture_sum_q", sum64_q, 64'd11);

    // Random stimulus against the arithmetic model
    m_sum_q = sum64_q; m_cout_q = cout64_q; m_ovf_q = ovf64_q;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a64   = {$urandom, $urandom};
      b64   = {$urandom, $urandom};
      cin64 = 1'($urandom_range(0, 1));
      en64  = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      r  = ref_add(a64, b64, cin64);
      ov = ref_ovf(a64, b64, cin64);
      #1;
      chk("rand_sum", sum64, r[63:0]);
      chk("rand_cout", {63'd0, cout64}, {63'd0, r[64]});
      if (en64) begin
        m_sum_q = r[63:0]; m_cout_q = r[64]; m_ovf_q = ov;
      end
      @(posedge clk); #1;
      chk("rand_sum_q", sum64_q, m_sum_q);
      chk("rand_cout_q", {63'd0, cout64_q}, {63'd0, m_cout_q});
      chk("rand_ovf_q", {63'd0, ovf64_q}, {63'd0, m_ovf_q});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_full_adder

// File: doc/full_adder.md
# full_adder

Binary adder at the leaf of the ALU adder hierarchy. Computes sum and carry-out of two WIDTH-bit operands plus a carry-in. The combinational result is a ripple-carry chain of 1-bit cells. A registered copy, with carry and signed-overflow flags, feeds the pipelined ALU datapath. With WIDTH=1 the block is the classic 1-bit full adder.

## Interface
Parameters:
- WIDTH, 1: operand width in bits; legal range 1–64.

Ports:
- clk, input, 1: single clock; all registers update on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- a, input, WIDTH: operand A, unsigned or two's complement.
- b, input, WIDTH: operand B.
- c_in, input, 1: carry into bit 0.
- en, input, 1: load enable for the registered outputs.
- sum, output, WIDTH: combinational (a + b + c_in) mod 2^WIDTH.
- c_out, output, 1: combinational carry out of bit WIDTH-1.
- sum_q, output, WIDTH: registered sum.
- c_out_q, output, 1: registered carry-out.
- ovf_q, output, 1: registered two's-complement overflow.

## Operation
- Per-bit cell i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i])
  - c[0] = c_in
- Combinational outputs:
  - sum = s[WIDTH-1:0]
  - c_out = c[WIDTH]
  - {c_out, sum} equals a + b + c_in exactly, as a (WIDTH+1)-bit result.
- Overflow = c[WIDTH] ^ c[WIDTH-1], with c[WIDTH-1] taken from the cell chain.
  - For WIDTH=1, overflow = c[1] ^ c_in.
- Registered stage:
  - On posedge clk with en=1: sum_q ← sum, c_out_q ← c_out, ovf_q ← overflow.
  - With en=0: all registered outputs hold.
- Reset:
  - rst=1 clears sum_q, c_out_q and ovf_q to 0 immediately, independent of clk.
  - Reset dominates en.
  - sum and c_out are never affected by reset; they track inputs at all times.
- Inputs carrying X/Z are not defined. The bench drives known values only.
- Boundary cases:
  - All-ones + all-ones + 1 gives sum = all ones, c_out = 1.
  - All-ones + 0 + 1 wraps: sum = 0, c_out = 1.
  - 0 + 0 + 0 gives all zeros.

## Timing
- sum and c_out: zero-cycle combinational path from a, b and c_in.
  - Worst case is a full ripple across WIDTH cells.
  - No latch and no clocked element on this path.
- sum_q, c_out_q, ovf_q: one-cycle latency.
  - They reflect the inputs sampled at the rising edge where en=1.
  - The new value is visible after that edge.
- Reset behaviour:
  - Assertion: outputs go to 0 asynchronously.
  - Deassertion: the first capture happens at the first posedge with rst=0 and en=1.
  - Reset asserted in the same cycle as en: reset wins, registers stay 0.
- Back-to-back en=1 cycles capture a new result every cycle. There is no handshake or backpressure.

## Structure
- Sub-module fa_cell: the 1-bit full adder with ports a, b, c_in, sum, c_out.
  - full_adder instantiates WIDTH copies in a generate loop, chained through an internal carry vector c[WIDTH:0].
- Shared ALU package holds:
  - the maximum-width constant ADDER_MAX_WIDTH = 64
  - a reset-value constant of 0 for flag registers.
- No typedefs are required.

## Test plan
- WIDTH=1, exhaustive combinational check: sweep all 8 combinations of {a, b, c_in} at 10 ns spacing.
  - {c_out, sum} equals a + b + c_in.
  - Expected results: 000→00, 001→01, 010→01, 011→10, 100→01, 101→10, 110→10, 111→11.
- WIDTH=64, carry propagation: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1.
  - sum=0, c_out=1, overflow=0.
  - With en=1, after one posedge: sum_q=0, c_out_q=1.
- WIDTH=64, signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, c_in=0.
  - sum=64'h8000_0000_0000_0000, c_out=0, ovf_q=1 after the capturing edge.
- Enable hold: capture 3+4+0 with en=1, giving sum_q=7.
  - Then drive 9+9+1 with en=0 for 3 cycles.
  - sum_q stays 7 while combinational sum=19.
- Asynchronous reset: with sum_q nonzero, pulse rst mid-cycle with no clock edge.
  - sum_q, c_out_q and ovf_q go to 0 immediately.
  - With rst and en both high at a posedge, the registers remain 0.
- Random: 1000 random a, b, c_in at WIDTH=64.
  - Combinational outputs are compared against a + b + c_in.
  - Registered outputs are compared one cycle later.
